sram_controller: RTL and testbench

Memory-side responder for the pipeline's MEM stage. It accepts 32-bit word read and write requests from the MEM stage and performs each one as two 16-bit accesses to an external asynchronous SRAM. A `ready` handshake tells the pipeline to freeze until the access completes. It sits between the MEM stage's address/data/enable outputs and the board SRAM pins, replacing the on-chip data memory.

---
 rtl/sram_controller.sv | 154 +++++++++++++++
 tb/tb_sram_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// sram_controller: 32-bit MEM-stage word access over a 16-bit async SRAM, low half then high half.
// Latency: ready in cycle 2*PHASE_CYCLES+1 after the request cycle; back-to-back words cost 2P+2 cycles.
// Backpressure: ready low freezes the pipeline; `SRAM_POSTED_WRITE_EN retires writes in the request cycle.
module sram_controller #(
  parameter int PHASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int CW = $clog2(PHASE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [16:0]   word_addr;
  logic [31:0]   wdata;
  logic          is_wr;
  logic [15:0]   rd_lo;
  logic          req;
  logic          in_phase;
  logic          phase_end;
  logic          dq_oe;
  logic [15:0]   dq_out;
  logic          posted_req;
  logic          posted_wr;
  logic          unused_addr_bits;

  assign req       = rd_en | wr_en;
  assign in_phase  = (state == LOW) || (state == HIGH);
  assign phase_end = in_phase && (cnt == LAST);

  // Byte-lane bits and the address space above the SRAM are not decoded.
  assign unused_addr_bits = ^{address[31:19], address[1:0]};

  // The SRAM chip is permanently selected with both byte lanes enabled.
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign SRAM_DQ = dq_oe ? dq_out : 16'bz;

`ifdef SRAM_POSTED_WRITE_EN
  // A write (including rd_en&wr_en, which is a write) is acknowledged immediately.
  assign posted_req = wr_en;

  // Remember whether the access in flight was acknowledged up front.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      posted_wr <= 1'b0;
    end else if (state == IDLE && req) begin
      posted_wr <= posted_req;
    end
  end
`else
  assign posted_req = 1'b0;
  assign posted_wr  = 1'b0;
`endif

  // State register and per-phase cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (in_phase && !phase_end) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  // Next-state: two equal-length half-word phases, then a one-cycle DONE unless posted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = LOW;
      LOW:     if (phase_end) state_nxt = HIGH;
      HIGH:    if (phase_end) state_nxt = posted_wr ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the request at acceptance and assemble read data from the two half-words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_addr <= '0;
      wdata     <= '0;
      is_wr     <= 1'b0;
      rd_lo     <= '0;
      readData  <= '0;
    end else begin
      if (state == IDLE && req) begin
        word_addr <= address[18:2];
        wdata     <= writeData;
        is_wr     <= wr_en;
      end
      if (phase_end && !is_wr) begin
        if (state == LOW) begin
          rd_lo <= SRAM_DQ;
        end else begin
          readData <= {SRAM_DQ, rd_lo};
        end
      end
    end
  end

  // SRAM pin control and pipeline handshake. WE_N rises in the last cycle of each
  // write phase so address and data stay stable past the rising edge.
  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = wdata[15:0];
    ready     = 1'b0;
    case (state)
      IDLE: ready = !req || posted_req;
      LOW, HIGH: begin
        SRAM_ADDR = {word_addr, (state == HIGH)};
        if (is_wr) begin
          SRAM_WE_N = (cnt == LAST);
          dq_oe     = 1'b1;
          dq_out    = (state == HIGH) ? wdata[31:16] : wdata[15:0];
        end else begin
          SRAM_OE_N = 1'b0;
        end
        ready = posted_wr ? !req : 1'b0;
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: drives MEM-stage word accesses against a small async SRAM model.
// Expected half-word writes and read words are queued as stimulus is issued and compared as the DUT produces them.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n;
  logic        oe_n;
  logic        ce_n;
  logic        ub_n;
  logic        lb_n;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int          cyc;
    logic [17:0] addr;
    logic [15:0] dat;
  } wr_ev_t;

  wr_ev_t      exp_wr_q[$];
  wr_ev_t      obs_wr_q[$];
  logic [31:0] exp_rd_q[$];

  int          ready_cyc;
  int          first_oe;
  logic [31:0] rd_at_ready;

  logic [15:0] mem [0:1023];

  sram_controller #(.PHASE_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .address   (address),
    .writeData (writeData),
    .readData  (readData),
    .ready     (ready),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (we_n),
    .SRAM_OE_N (oe_n),
    .SRAM_CE_N (ce_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: drives the bus while output-enabled, stores while write-enabled.
  assign sram_dq = (!oe_n) ? mem[sram_addr[9:0]] : 16'bz;

  always @(posedge clk) begin
    if (!we_n) mem[sram_addr[9:0]] = sram_dq;
  end

  // Present a request at the start of cycle 0 and run until ready (bounded).
  // Records write strobes, first OE cycle and readData in the ready cycle.
  // Returns at the start of the cycle after ready; enables are left as driven.
  task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd);
    rd_en     = r;
    wr_en     = w;
    address   = a;
    writeData = wd;
    ready_cyc = -1;
    first_oe  = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!we_n) obs_wr_q.push_back('{c, sram_addr, sram_dq});
      if (!oe_n && first_oe < 0) first_oe = c;
      if (ready) begin
        ready_cyc   = c;
        rd_at_ready = readData;
      end
      @(posedge clk);
      #1;
      if (ready_cyc >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    address = '0;
    writeData = '0;
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (readData !== 32'h0) begin fails++; $display("FAIL reset_readData: got %h expected 00000000", readData); end
    checks++; if (we_n !== 1'b1) begin fails++; $display("FAIL reset_we_n: got %b expected 1", we_n); end
    checks++; if (oe_n !== 1'b1) begin fails++; $display("FAIL reset_oe_n: got %b expected 1", oe_n); end
    checks++; if (sram_addr !== 18'h0) begin fails++; $display("FAIL reset_addr: got %h expected 00000", sram_addr); end
    checks++; if ({ce_n, ub_n, lb_n} !== 3'b000) begin fails++; $display("FAIL reset_tieoffs: got %b expected 000", {ce_n, ub_n, lb_n}); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({ready, we_n, oe_n} !== 3'b111) begin fails++; $display("FAIL idle_pins: got %b expected 111 cycle %0d", {ready, we_n, oe_n}, i); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_write();
    wr_ev_t e;
    wr_ev_t o;
    exp_wr_q.push_back('{1, 18'h200, 16'h5678});
    exp_wr_q.push_back('{3, 18'h201, 16'h1234});
    issue(1'b0, 1'b1, 32'h400, 32'h12345678);
    wr_en = 1'b0;
    checks++; if (ready_cyc != 5) begin fails++; $display("FAIL write_ready_cycle: got %0d expected 5", ready_cyc); end
    checks++; if (obs_wr_q.size() != exp_wr_q.size()) begin fails++; $display("FAIL write_strobe_count: got %0d expected %0d", obs_wr_q.size(), exp_wr_q.size()); end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      o = obs_wr_q.pop_front();
      checks++;
      if (o.cyc != e.cyc || o.addr !== e.addr || o.dat !== e.dat) begin
        fails++;
        $display("FAIL write_strobe: got cyc %0d addr %h dq %h expected cyc %0d addr %h dq %h", o.cyc, o.addr, o.dat, e.cyc, e.addr, e.dat);
      end
    end
    exp_wr_q.delete();
    obs_wr_q.delete();
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL write_idle_after: got %b expected 1", ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_read_back();
    logic [31:0] e;
    exp_rd_q.push_back(32'h12345678);
    issue(1'b1, 1'b0, 32'h400, 32'h0);
    rd_en = 1'b0;
    e = exp_rd_q.pop_front();
    checks++; if (ready_cyc != 5) begin fails++; $display("FAIL read_ready_cycle: got %0d expected 5", ready_cyc); end
    checks++; if (rd_at_ready !== e) begin fails++; $display("FAIL read_data: got %h expected %h", rd_at_ready, e); end
    checks++; if (obs_wr_q.size() != 0) begin fails++; $display("FAIL read_no_write: got %0d strobes expected 0", obs_wr_q.size()); end
    obs_wr_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (readData !== e) begin fails++; $display("FAIL read_data_held: got %h expected %h", readData, e); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_simultaneous();
    wr_ev_t      e;
    wr_ev_t      o;
    logic [31:0] er;
    exp_wr_q.push_back('{1, 18'h200, 16'hF00D});
    exp_wr_q.push_back('{3, 18'h201, 16'hCAFE});
    issue(1'b1, 1'b1, 32'h403, 32'hCAFEF00D);
    rd_en = 1'b0;
    wr_en = 1'b0;
    checks++; if (ready_cyc != 5) begin fails++; $display("FAIL both_ready_cycle: got %0d expected 5", ready_cyc); end
    checks++; if (readData !== 32'h12345678) begin fails++; $display("FAIL both_readData_kept: got %h expected 12345678", readData); end
    checks++; if (obs_wr_q.size() != exp_wr_q.size()) begin fails++; $display("FAIL both_strobe_count: got %0d expected %0d", obs_wr_q.size(), exp_wr_q.size()); end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      o = obs_wr_q.pop_front();
      checks++;
      if (o.cyc != e.cyc || o.addr !== e.addr || o.dat !== e.dat) begin
        fails++;
        $display("FAIL both_strobe: got cyc %0d addr %h dq %h expected cyc %0d addr %h dq %h", o.cyc, o.addr, o.dat, e.cyc, e.addr, e.dat);
      end
    end
    exp_wr_q.delete();
    obs_wr_q.delete();
    exp_rd_q.push_back(32'hCAFEF00D);
    issue(1'b1, 1'b0, 32'h400, 32'h0);
    rd_en = 1'b0;
    er = exp_rd_q.pop_front();
    checks++; if (rd_at_ready !== er) begin fails++; $display("FAIL both_readback: got %h expected %h", rd_at_ready, er); end
  endtask

  task automatic test_back_to_back();
    int          c1;
    logic [31:0] d1;
    logic [31:0] e;
    exp_rd_q.push_back(32'h22221111);
    exp_rd_q.push_back(32'h44443333);
    issue(1'b1, 1'b0, 32'h0, 32'h0);
    c1 = ready_cyc;
    d1 = rd_at_ready;
    issue(1'b1, 1'b0, 32'h4, 32'h0);
    rd_en = 1'b0;
    checks++; if (c1 != 5) begin fails++; $display("FAIL b2b_first_ready: got %0d expected 5", c1); end
    checks++; if (6 + ready_cyc != 11) begin fails++; $display("FAIL b2b_second_ready: got %0d expected 11", 6 + ready_cyc); end
    checks++; if (6 + first_oe != 7) begin fails++; $display("FAIL b2b_second_low: got %0d expected 7", 6 + first_oe); end
    e = exp_rd_q.pop_front();
    checks++; if (d1 !== e) begin fails++; $display("FAIL b2b_data0: got %h expected %h", d1, e); end
    e = exp_rd_q.pop_front();
    checks++; if (rd_at_ready !== e) begin fails++; $display("FAIL b2b_data1: got %h expected %h", rd_at_ready, e); end
    obs_wr_q.delete();
  endtask

`ifdef SRAM_POSTED_WRITE_EN
  task automatic test_posted_write();
    wr_ev_t      e;
    wr_ev_t      o;
    logic [31:0] er;
    issue(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    checks++; if (ready_cyc != 0) begin fails++; $display("FAIL posted_ready: got %0d expected 0", ready_cyc); end
    // Read issued in cycle 1; write strobes now land in the read's local cycles 0 and 2.
    exp_wr_q.push_back('{0, 18'h020, 16'hBEEF});
    exp_wr_q.push_back('{2, 18'h021, 16'hDEAD});
    exp_rd_q.push_back(32'hDEADBEEF);
    wr_en = 1'b0;
    issue(1'b1, 1'b0, 32'h40, 32'h0);
    rd_en = 1'b0;
    checks++; if (1 + ready_cyc != 10) begin fails++; $display("FAIL posted_read_ready: got %0d expected 10", 1 + ready_cyc); end
    checks++; if (1 + first_oe != 6) begin fails++; $display("FAIL posted_read_low: got %0d expected 6", 1 + first_oe); end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      o = obs_wr_q.pop_front();
      checks++;
      if (o.cyc != e.cyc || o.addr !== e.addr || o.dat !== e.dat) begin
        fails++;
        $display("FAIL posted_strobe: got cyc %0d addr %h dq %h expected cyc %0d addr %h dq %h", o.cyc, o.addr, o.dat, e.cyc, e.addr, e.dat);
      end
    end
    checks++; if (exp_wr_q.size() != 0) begin fails++; $display("FAIL posted_strobe_missing: got %0d left expected 0", exp_wr_q.size()); end
    exp_wr_q.delete();
    obs_wr_q.delete();
    er = exp_rd_q.pop_front();
    checks++; if (rd_at_ready !== er) begin fails++; $display("FAIL posted_readback: got %h expected %h", rd_at_ready, er); end
  endtask
`endif

  task automatic test_reset_mid_read();
    logic [31:0] e;
    rd_en = 1'b1;
    address = 32'h400;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++; if (oe_n !== 1'b0) begin fails++; $display("FAIL midrst_in_read: got oe_n %b expected 0", oe_n); end
    rst = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    checks++; if (readData !== 32'h0) begin fails++; $display("FAIL midrst_readData: got %h expected 00000000", readData); end
    checks++; if ({we_n, oe_n} !== 2'b11) begin fails++; $display("FAIL midrst_enables: got %b expected 11", {we_n, oe_n}); end
    checks++; if (sram_addr !== 18'h0) begin fails++; $display("FAIL midrst_addr: got %h expected 00000", sram_addr); end
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b expected 1", ready); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({ready, oe_n} !== 2'b11) begin fails++; $display("FAIL midrst_idle_after: got %b expected 11", {ready, oe_n}); end
    @(posedge clk);
    #1;
    exp_rd_q.push_back(32'hCAFEF00D);
    issue(1'b1, 1'b0, 32'h400, 32'h0);
    rd_en = 1'b0;
    e = exp_rd_q.pop_front();
    checks++; if (ready_cyc != 5) begin fails++; $display("FAIL midrst_reread_cycle: got %0d expected 5", ready_cyc); end
    checks++; if (rd_at_ready !== e) begin fails++; $display("FAIL midrst_reread_data: got %h expected %h", rd_at_ready, e); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[3] = 16'h4444;
    test_reset();
    test_idle();
    test_write();
    test_read_back();
    test_simultaneous();
    test_back_to_back();
`ifdef SRAM_POSTED_WRITE_EN
    test_posted_write();
`endif
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
